// File: rtl/bird_sprite_ctrl.sv
// Bird flap-animation sequencer and sprite-ROM pixel pipeline (2-clock latency).
// Optional 2x drawing scale is enabled by defining BIRD_SPRITE_SCALE2_EN.
module bird_sprite_ctrl #(
    parameter int          SPRITE_W   = 18,
    parameter int          SPRITE_H   = 12,
    parameter int          FRAME_HOLD = 4,
    parameter logic [23:0] KEY_COLOUR = 24'hFF0096,
    parameter int          COORD_W    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               flap,
    input  logic               dead,
    input  logic               restart,
    input  logic               pixel_valid,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic [COORD_W-1:0] bird_x,
    input  logic [COORD_W-1:0] bird_y,
    input  logic [23:0]        frame0_data,
    input  logic [23:0]        frame1_data,
    input  logic [23:0]        frame2_data,
    output logic [3:0]         rom_row,
    output logic [4:0]         rom_col,
    output logic [1:0]         frame_sel,
    output logic [1:0]         anim_state,
    output logic [23:0]        sprite_rgb,
    output logic               sprite_hit,
    output logic               out_valid
);

`ifdef BIRD_SPRITE_SCALE2_EN
    localparam int BOX_W = 2 * SPRITE_W;
    localparam int BOX_H = 2 * SPRITE_H;
`else
    localparam int BOX_W = SPRITE_W;
    localparam int BOX_H = SPRITE_H;
`endif
    localparam logic signed [COORD_W:0] BOX_W_L = (COORD_W+1)'(BOX_W);
    localparam logic signed [COORD_W:0] BOX_H_L = (COORD_W+1)'(BOX_H);

    localparam int               HOLD_W    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FRAME_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLAP = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    state_t            state_r, state_nx;
    logic [1:0]        step_r, step_nx;
    logic [HOLD_W-1:0] hold_r, hold_nx;
    logic [1:0]        fsel_r, fsel_nx;
    logic              flap_p_r, flap_p_nx;
    logic              dead_p_r, dead_p_nx;
    logic              restart_p_r, restart_p_nx;
    logic              flap_eff_s, dead_eff_s, restart_eff_s;

    // Animation state register and sticky command flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            step_r      <= 2'd0;
            hold_r      <= '0;
            fsel_r      <= 2'd0;
            flap_p_r    <= 1'b0;
            dead_p_r    <= 1'b0;
            restart_p_r <= 1'b0;
        end else begin
            state_r     <= state_nx;
            step_r      <= step_nx;
            hold_r      <= hold_nx;
            fsel_r      <= fsel_nx;
            flap_p_r    <= flap_p_nx;
            dead_p_r    <= dead_p_nx;
            restart_p_r <= restart_p_nx;
        end
    end

    assign flap_eff_s    = flap | flap_p_r;
    assign dead_eff_s    = dead | dead_p_r;
    assign restart_eff_s = restart | restart_p_r;

    // Next-state: commands only take effect on frame_tick so a frame never tears mid-scan.
    always_comb begin
        state_nx     = state_r;
        step_nx      = step_r;
        hold_nx      = hold_r;
        fsel_nx      = fsel_r;
        flap_p_nx    = flap_eff_s;
        dead_p_nx    = dead_eff_s;
        restart_p_nx = restart_eff_s;
        if (frame_tick) begin
            flap_p_nx    = 1'b0;
            dead_p_nx    = 1'b0;
            restart_p_nx = 1'b0;
            if (restart_eff_s) begin
                state_nx = ST_IDLE;
                step_nx  = 2'd0;
                hold_nx  = '0;
                fsel_nx  = 2'd0;
            end else if (dead_eff_s || (state_r == ST_DEAD)) begin
                state_nx = ST_DEAD;
            end else if (flap_eff_s) begin
                state_nx = ST_FLAP;
                step_nx  = 2'd0;
                hold_nx  = '0;
                fsel_nx  = 2'd1;
            end else if (state_r == ST_FLAP) begin
                if (hold_r == HOLD_LAST) begin
                    hold_nx = '0;
                    case (step_r)
                        2'd0: begin
                            step_nx = 2'd1;
                            fsel_nx = 2'd2;
                        end
                        2'd1: begin
                            step_nx = 2'd2;
                            fsel_nx = 2'd1;
                        end
                        default: begin
                            state_nx = ST_IDLE;
                            step_nx  = 2'd0;
                            fsel_nx  = 2'd0;
                        end
                    endcase
                end else begin
                    hold_nx = hold_r + HOLD_W'(1);
                end
            end else begin
                state_nx = state_r;
            end
        end else begin
            state_nx = state_r;
        end
    end

    // Stage 0: signed offsets never wrap, so a bird hanging off the right edge shows no ghost.
    logic signed [COORD_W:0] dx_s, dy_s;
    logic                    in_box_s;
    logic [3:0]              row_s;
    logic [4:0]              col_s;

    assign dx_s = $signed({1'b0, pixel_x}) - $signed({1'b0, bird_x});
    assign dy_s = $signed({1'b0, pixel_y}) - $signed({1'b0, bird_y});
    assign in_box_s = pixel_valid & ~dx_s[COORD_W] & (dx_s < BOX_W_L)
                    & ~dy_s[COORD_W] & (dy_s < BOX_H_L);
`ifdef BIRD_SPRITE_SCALE2_EN
    assign col_s = dx_s[5:1];
    assign row_s = dy_s[4:1];
`else
    assign col_s = dx_s[4:0];
    assign row_s = dy_s[3:0];
`endif

    logic [3:0]  row_r;
    logic [4:0]  col_r;
    logic        in_box_d1_r, valid_d1_r, in_box_d2_r, valid_d2_r;
    logic [1:0]  fsel_d1_r, fsel_d2_r;
    logic [23:0] colour_s;
    logic        hit_s;
    logic [23:0] rgb_r;
    logic        hit_r, out_valid_r;

    // Pixel pipeline: address at E0, control delayed to meet ROM data at E2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_r       <= 4'd0;
            col_r       <= 5'd0;
            in_box_d1_r <= 1'b0;
            valid_d1_r  <= 1'b0;
            fsel_d1_r   <= 2'd0;
            in_box_d2_r <= 1'b0;
            valid_d2_r  <= 1'b0;
            fsel_d2_r   <= 2'd0;
            rgb_r       <= 24'h000000;
            hit_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            row_r       <= in_box_s ? row_s : 4'd0;
            col_r       <= in_box_s ? col_s : 5'd0;
            in_box_d1_r <= in_box_s;
            valid_d1_r  <= pixel_valid;
            fsel_d1_r   <= fsel_r;
            in_box_d2_r <= in_box_d1_r;
            valid_d2_r  <= valid_d1_r;
            fsel_d2_r   <= fsel_d1_r;
            rgb_r       <= hit_s ? colour_s : 24'h000000;
            hit_r       <= hit_s;
            out_valid_r <= valid_d2_r;
        end
    end

    // Stage 2 colour select and transparency key.
    always_comb begin
        colour_s = frame2_data;
        case (fsel_d2_r)
            2'd0:    colour_s = frame0_data;
            2'd1:    colour_s = frame1_data;
            default: colour_s = frame2_data;
        endcase
        hit_s = in_box_d2_r & (colour_s != KEY_COLOUR);
    end

    assign rom_row    = row_r;
    assign rom_col    = col_r;
    assign frame_sel  = fsel_r;
    assign anim_state = state_r;
    assign sprite_rgb = rgb_r;
    assign sprite_hit = hit_r;
    assign out_valid  = out_valid_r;

endmodule

// File: tb/tb_bird_sprite_ctrl.sv
// Directed bench for bird_sprite_ctrl: ROM model, pixel scoreboard and animation checks.
module tb_bird_sprite_ctrl;

    localparam logic [23:0] KEY = 24'hFF0096;
`ifdef BIRD_SPRITE_SCALE2_EN
    localparam int SC = 2;
`else
    localparam int SC = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0, flap = 1'b0, dead = 1'b0, restart = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [9:0]  pixel_x = 10'd0, pixel_y = 10'd0;
    logic [9:0]  bird_x = 10'd100, bird_y = 10'd50;
    logic [23:0] frame0_data = 24'h0, frame1_data = 24'h0, frame2_data = 24'h0;
    logic [3:0]  rom_row;
    logic [4:0]  rom_col;
    logic [1:0]  frame_sel, anim_state;
    logic [23:0] sprite_rgb;
    logic        sprite_hit, out_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [1:0] exp_fsel = 2'd0;

    typedef struct packed {
        logic [31:0] due;
        logic        hit;
        logic [23:0] rgb;
    } sb_t;
    sb_t sb_q[$];
    sb_t sb_e;

    bird_sprite_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .flap(flap), .dead(dead),
        .restart(restart), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .bird_x(bird_x), .bird_y(bird_y), .frame0_data(frame0_data),
        .frame1_data(frame1_data), .frame2_data(frame2_data), .rom_row(rom_row),
        .rom_col(rom_col), .frame_sel(frame_sel), .anim_state(anim_state),
        .sprite_rgb(sprite_rgb), .sprite_hit(sprite_hit), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] rom_fn(input int f, input int row, input int col);
        logic [23:0] c;
        if (f == 0 && row == 0 && col == 6) c = 24'h533846;
        else if (f == 0 && row == 0 && col == 0) c = KEY;
        else c = {4'(f + 1), 4'h0, 4'(row), 3'b000, 5'(col), 4'h5};
        return c;
    endfunction

    // Three sprite ROMs: registered address, one-clock read latency.
    always @(posedge clk) begin
        frame0_data <= rom_fn(0, int'(rom_row), int'(rom_col));
        frame1_data <= rom_fn(1, int'(rom_row), int'(rom_col));
        frame2_data <= rom_fn(2, int'(rom_row), int'(rom_col));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every valid output must match the oldest pending pixel and arrive on time.
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra_out", 32'(sb_q.size()), 32'd1);
            end else begin
                sb_e = sb_q.pop_front();
                chk("latency", 32'(cyc), sb_e.due);
                chk("sprite_hit", 32'(sprite_hit), 32'(sb_e.hit));
                chk("sprite_rgb", 32'(sprite_rgb), 32'(sb_e.rgb));
            end
        end
    end

    task automatic drive_pixel(input int x, input int y);
        int dx, dy, row, col;
        logic inb;
        logic [23:0] c;
        sb_t e;
        dx  = x - int'(bird_x);
        dy  = y - int'(bird_y);
        inb = (dx >= 0) && (dx < 18 * SC) && (dy >= 0) && (dy < 12 * SC);
        row = inb ? dy / SC : 0;
        col = inb ? dx / SC : 0;
        c   = rom_fn(int'(exp_fsel), row, col);
        e.due = 32'(cyc + 3);
        e.hit = inb && (c != KEY);
        e.rgb = e.hit ? c : 24'h0;
        sb_q.push_back(e);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        pixel_valid = 1'b1;
        @(negedge clk);
        pixel_valid = 1'b0;
        chk("rom_row", 32'(rom_row), 32'(row));
        chk("rom_col", 32'(rom_col), 32'(col));
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_cmd(input logic f, input logic d, input logic r);
        flap = f; dead = d; restart = r;
        @(negedge clk);
        flap = 1'b0; dead = 1'b0; restart = 1'b0;
    endtask

    task automatic chk_anim(input string tag, input int st, input int fs);
        chk({tag, "_state"}, 32'(anim_state), 32'(st));
        chk({tag, "_fsel"}, 32'(frame_sel), 32'(fs));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_row"}, 32'(rom_row), 32'd0);
        chk({tag, "_col"}, 32'(rom_col), 32'd0);
        chk({tag, "_fsel"}, 32'(frame_sel), 32'd0);
        chk({tag, "_state"}, 32'(anim_state), 32'd0);
        chk({tag, "_rgb"}, 32'(sprite_rgb), 32'd0);
        chk({tag, "_hit"}, 32'(sprite_hit), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    endtask

    function automatic int flap_fsel(input int rel);
        if (rel < 4) return 1;
        else if (rel < 8) return 2;
        else if (rel < 12) return 1;
        else return 0;
    endfunction

    initial begin
        int rel;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Pixel mapping in IDLE (frame 0), including edges and back-to-back pixels.
        drive_pixel(106, 50);
        drive_pixel(100, 50);
        drive_pixel(99, 50);
        drive_pixel(118, 50);
        drive_pixel(117, 61);
        drive_pixel(105, 62);
        drive_pixel(110, 49);
        bird_x = 10'd1020;
        drive_pixel(2, 55);
        drive_pixel(1023, 55);
        drive_pixel(1019, 55);
        repeat (3) @(negedge clk);
        bird_x = 10'd100;

        // Full flap sequence.
        pulse_cmd(1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= 12; i++) begin
            do_tick();
            chk_anim("flap_seq", (i < 12) ? 1 : 0, flap_fsel(i));
        end

        // Retrigger between T5 and T6, with pixels read from frames 1 and 2.
        pulse_cmd(1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= 18; i++) begin
            if (i == 6) pulse_cmd(1'b1, 1'b0, 1'b0);
            do_tick();
            rel = (i < 6) ? i : i - 6;
            chk_anim("retrig", (rel < 12) ? 1 : 0, flap_fsel(rel));
            if (i == 7 || i == 11) begin
                exp_fsel = 2'(flap_fsel(rel));
                drive_pixel(103, 52);
                drive_pixel(117, 61);
                exp_fsel = 2'd0;
            end
        end

        // Dead and flap pending at the same tick; dead wins and freezes frame 2.
        pulse_cmd(1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= 4; i++) do_tick();
        chk_anim("pre_dead", 1, 2);
        pulse_cmd(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            do_tick();
            chk_anim("dead", 2, 2);
        end
        pulse_cmd(1'b1, 1'b0, 1'b0);
        do_tick();
        chk_anim("dead_flap", 2, 2);
        restart = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        frame_tick = 1'b0;
        @(negedge clk);
        chk_anim("restart", 0, 0);

        // A pending flap waits for the tick.
        pulse_cmd(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk_anim("no_tick", 0, 0);
        do_tick();
        chk_anim("late_tick", 1, 1);

        // Asynchronous reset mid-flap while a hit is on the outputs.
        for (int i = 0; i < 4; i++) do_tick();
        chk_anim("pre_reset", 1, 2);
        exp_fsel = 2'd2;
        drive_pixel(106, 50);
        exp_fsel = 2'd0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_anim("post_reset", 0, 0);
        do_tick();
        chk_anim("post_reset_tick", 0, 0);

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bird_sprite_ctrl.md
Name: bird_sprite_ctrl

Overview:
- Sequencer for the three bird flap-frame sprite ROMs: flap frame 1, flap frame 2 and flap frame 3.
- Each ROM is 12 rows x 18 cols x 24-bit colour, with a registered address and a 1-clock read latency.
- Maps the raster pixel coordinate onto a ROM row/col address and selects the active animation frame.
- Realigns the returned colour with the pixel pipeline and applies the transparency key.
- Sits between the VGA timing/game-state logic and the pixel compositor.

Parameters:
- SPRITE_W, 18, sprite width in pixels (ROM col range 0..17).
- SPRITE_H, 12, sprite height in pixels (ROM row range 0..11).
- FRAME_HOLD, 4, frame_tick count each animation step is held (must be >=1).
- KEY_COLOUR, 24'hFF0096, transparent colour.
- COORD_W, 10, pixel/bird coordinate width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame, issued in vblank.
- flap  in  1  one-cycle pulse: start flap animation.
- dead  in  1  one-cycle pulse: freeze animation.
- restart  in  1  one-cycle pulse: return to idle.
- pixel_valid  in  1  pixel_x/pixel_y are valid this cycle.
- pixel_x  in  COORD_W  current raster x.
- pixel_y  in  COORD_W  current raster y.
- bird_x  in  COORD_W  sprite top-left x.
- bird_y  in  COORD_W  sprite top-left y.
- frame0_data  in  24  colour_data from flap frame 1 ROM.
- frame1_data  in  24  colour_data from flap frame 2 ROM.
- frame2_data  in  24  colour_data from flap frame 3 ROM.
- rom_row  out  4  row address to all three ROMs.
- rom_col  out  5  col address to all three ROMs.
- frame_sel  out  2  active frame index, 0..2.
- anim_state  out  2  0=IDLE, 1=FLAP, 2=DEAD.
- sprite_rgb  out  24  sprite colour; 0 when sprite_hit=0.
- sprite_hit  out  1  opaque sprite pixel.
- out_valid  out  1  sprite_rgb/sprite_hit valid.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; state IDLE; step 0; hold count 0; all pending flags clear. Reset mid-flap returns to IDLE/frame 0 immediately.
- Pending flags: flap, dead and restart pulses each set a sticky pending flag. A pulse arriving in the same cycle as frame_tick is applied at that tick. All pending flags are cleared on every frame_tick.
- Frame updates happen only on frame_tick, so there is no tearing mid-scan. Priority at a tick: restart > dead > flap > step advance.
  - restart: go to IDLE, frame_sel=0.
  - dead: go to DEAD from IDLE or FLAP; frame_sel holds its current value. In DEAD, flap is ignored; only restart or reset exits.
  - flap (IDLE or FLAP): go to FLAP, step=0, hold=0, frame_sel=1. A flap during FLAP restarts the sequence.
- FLAP step sequence: step 0 shows frame 1, step 1 frame 2, step 2 frame 1.
  - On each non-command tick: if hold == FRAME_HOLD-1, then hold=0 and step++; otherwise hold++.
  - Advancing past step 2 goes to IDLE, frame_sel=0.
- Pixel pipeline, stage 0 (edge E0, pixel sampled):
  - dx = pixel_x - bird_x and dy = pixel_y - bird_y, computed as COORD_W+1-bit signed values.
  - in_box = pixel_valid & dx>=0 & dx<SPRITE_W & dy>=0 & dy<SPRITE_H.
  - rom_row = dy[3:0], rom_col = dx[4:0] when in_box, else 0.
  - in_box, pixel_valid and frame_sel are registered alongside.
- Stage 1: each ROM captures its address at E1; colour data is valid after E1.
- Stage 2 (E2):
  - out_valid = delayed pixel_valid.
  - The colour is muxed by the delayed frame_sel.
  - sprite_hit = delayed in_box & colour != KEY_COLOUR.
  - sprite_rgb = colour if sprite_hit, else 0.
- Latency: pixel sampled at E0, result at E2 (2 clocks). Full throughput, one pixel per clock, no stalls.
- Wrap-around: bird partly off-screen (bird_x + SPRITE_W > 2^COORD_W) produces no wrapped hits, because dx is signed and non-wrapping.

Optional Feature:
- Macro: BIRD_SPRITE_SCALE2_EN.
- Defined:
  - Sprite is drawn at 2x: the box is 2*SPRITE_W x 2*SPRITE_H.
  - rom_col = dx[5:1], rom_row = dy[4:1].
  - Latency is unchanged.
- Undefined: 1x mapping as above.

Test Plan:
- Reset: assert reset mid-FLAP with frame_sel=2 -> all outputs 0 asynchronously; after release, anim_state=0 and frame_sel=0.
- Opaque hit: bird (100,50), pixel (106,50), frame0_data=24'h533846 -> rom_row=0, rom_col=6 after E0; at E2 out_valid=1, sprite_hit=1, sprite_rgb=24'h533846.
- Key / out of box:
  - frame0_data=24'hFF0096 at pixel (100,50) -> sprite_hit=0, sprite_rgb=0.
  - pixel (99,50) or (118,50) -> sprite_hit=0, rom_row=0, rom_col=0.
- Flap sequence, FRAME_HOLD=4: flap pulse, then ticks T0..T12 -> frame_sel=1 at T0, 2 at T4, 1 at T8, 0 with anim_state=0 at T12.
- Retrigger: flap between T5 and T6 -> at T6 frame_sel=1, step=0; the sequence ends at T18.
- Priority: dead+flap before the same tick while frame_sel=2 -> anim_state=2, frame_sel stays 2 across 10 ticks; later flap ignored; restart -> anim_state=0, frame_sel=0 at the next tick.
